grid_io_tile_multi: RTL
=======================

GRID_IO_TILE_MULTI -- requirements
Module: grid_io_tile_multi

Interface
- REQ-001: The module SHALL have parameter NUM_PADS, default 4, giving the number of I/O pads in the tile; legal range 1..32.
- REQ-002: The module SHALL define derived constant CFG_BITS = 2*NUM_PADS, the configuration-chain length.
- REQ-003: The module SHALL have port prog_clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-004: The module SHALL have port prog_reset, input, 1 bit: synchronous, active-high reset.
- REQ-005: The module SHALL have port ccff_en, input, 1 bit: configuration shift enable.
- REQ-006: The module SHALL have port ccff_head, input, 1 bit: configuration chain serial in.
- REQ-007: The module SHALL have port ccff_tail, output, 1 bit: configuration chain serial out, equal to chain[CFG_BITS-1].
- REQ-008: The module SHALL have port cfg_done, output, 1 bit: high while a complete configuration is active.
- REQ-009: The module SHALL have port gfpga_pad_EMBEDDED_IO_SOC_IN, input, NUM_PADS bits: pad input from the SoC.
- REQ-010: The module SHALL have port gfpga_pad_EMBEDDED_IO_SOC_OUT, output, NUM_PADS bits: pad output to the SoC.
- REQ-011: The module SHALL have port gfpga_pad_EMBEDDED_IO_SOC_DIR, output, NUM_PADS bits: pad direction, 1 = output.
- REQ-012: The module SHALL have port pin_outpad, input, NUM_PADS bits: fabric data driven toward the pads.
- REQ-013: The module SHALL have port pin_inpad, output, NUM_PADS bits: pad data delivered to the fabric.

Function
- REQ-014: chain[CFG_BITS-1:0] SHALL shift on each cycle with ccff_en=1: chain[0]<=ccff_head, chain[k]<=chain[k-1]; it SHALL hold when ccff_en=0.
- REQ-015: Chain field mapping SHALL be chain[2i] = dir bit of pad i and chain[2i+1] = inv bit of pad i.
- REQ-016: A shift counter of width clog2(CFG_BITS+1) SHALL count accepted shifts; the FSM SHALL have states UNCFG, SHIFT and CFG.
- REQ-017: In UNCFG, ccff_en=1 SHALL move the FSM to SHIFT with count=1.
- REQ-018: In SHIFT, each ccff_en=1 SHALL increment count; when the shift making count==CFG_BITS occurs, the FSM SHALL enter CFG on the next edge, copy the post-shift chain into shadow registers act_dir/act_inv, and reset count to 0.
- REQ-019: In SHIFT, ccff_en=0 SHALL hold state and count; partial loads SHALL never alter the shadow registers.
- REQ-020: In CFG, ccff_en=1 SHALL start a reload (to SHIFT, count=1); the shadow registers and cfg_done SHALL stay unchanged until the reload completes, giving glitch-free reprogramming.
- REQ-021: cfg_done SHALL be 1 in CFG, and also in SHIFT when the FSM was entered from CFG; otherwise it SHALL be 0.
- REQ-022: gfpga_pad_EMBEDDED_IO_SOC_DIR[i] SHALL equal act_dir[i] AND cfg_valid, where cfg_valid is set on the first completed load and cleared only by reset.
- REQ-023: gfpga_pad_EMBEDDED_IO_SOC_OUT[i] SHALL equal pin_outpad[i] XOR act_inv[i] when SOC_DIR[i]=1, and 0 otherwise.
- REQ-024: pin_inpad[i] SHALL equal gfpga_pad_EMBEDDED_IO_SOC_IN[i] XOR act_inv[i] when SOC_DIR[i]=0 and cfg_valid=1, and 0 otherwise.
- REQ-025: prog_reset asserted together with ccff_en SHALL take priority; the shift SHALL be discarded.

Reset
- REQ-026: On prog_reset=1 at a clock edge, the following SHALL be cleared to 0 on that edge: chain, count, act_dir, act_inv and cfg_valid; the FSM SHALL return to UNCFG.
- REQ-027: After reset, the outputs SHALL be SOC_DIR=0, SOC_OUT=0, pin_inpad=0, cfg_done=0 and ccff_tail=0.
- REQ-028: A reset asserted mid-load SHALL abandon the load, and the next load SHALL start from count=0.

Configuration
- REQ-029: With macro GRID_IO_INPAD_REG_EN defined, pin_inpad SHALL be registered: one prog_clk cycle of latency, reset value 0.
- REQ-030: Without GRID_IO_INPAD_REG_EN, pin_inpad SHALL be purely combinational from SOC_IN, with zero latency.
- REQ-031: GRID_IO_INPAD_REG_EN SHALL not affect the SOC_OUT and SOC_DIR paths or the configuration logic.

Verification (NUM_PADS=2, CFG_BITS=4)
- REQ-032: Reset, then shift 1,0,0,1 with ccff_en=1 for 4 cycles -> cfg_done=1 on the next edge, SOC_DIR=2'b01, SOC_OUT[0]=pin_outpad[0], and pin_inpad[1]=~SOC_IN[1].
- REQ-033: Shift 3 bits, hold ccff_en=0 for 5 cycles, then shift 1 more bit -> the load completes with the correct config and no early cfg_done.
- REQ-034: From CFG (DIR=2'b01), shift 0,1,1,0 -> DIR stays 2'b01 for 3 cycles, then becomes 2'b10; cfg_done stays 1 throughout.
- REQ-035: Assert prog_reset after 2 shifts -> all outputs 0; a following full 4-bit load configures correctly.
- REQ-036: Observe ccff_tail while shifting 8 bits 1,1,0,1,0,0,1,0 -> the first 4 bits appear on ccff_tail at cycles 4-7.
- REQ-037: With GRID_IO_INPAD_REG_EN, toggle SOC_IN[1] -> pin_inpad[1] follows one cycle later; without the macro, it follows in the same cycle.

Source files
------------

// File: rtl/grid_io_tile_multi.sv
// Configurable I/O tile: serial config chain loads per-pad direction/invert bits into shadow registers.
// Optional macro GRID_IO_INPAD_REG_EN registers pin_inpad (one cycle latency); default is combinational.
module grid_io_tile_multi #(
    parameter int NUM_PADS = 4
) (
    input  logic                prog_clk,
    input  logic                prog_reset,
    input  logic                ccff_en,
    input  logic                ccff_head,
    output logic                ccff_tail,
    output logic                cfg_done,
    input  logic [NUM_PADS-1:0] gfpga_pad_EMBEDDED_IO_SOC_IN,
    output logic [NUM_PADS-1:0] gfpga_pad_EMBEDDED_IO_SOC_OUT,
    output logic [NUM_PADS-1:0] gfpga_pad_EMBEDDED_IO_SOC_DIR,
    input  logic [NUM_PADS-1:0] pin_outpad,
    output logic [NUM_PADS-1:0] pin_inpad
);
    localparam int CFG_BITS = 2 * NUM_PADS;
    localparam int CNT_W    = $clog2(CFG_BITS + 1);

    typedef enum logic [1:0] {UNCFG = 2'd0, SHIFT = 2'd1, CFG = 2'd2} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CFG_BITS-1:0]   chain_q, chain_d;
    logic [NUM_PADS-1:0]   act_dir_q, act_dir_d;
    logic [NUM_PADS-1:0]   act_inv_q, act_inv_d;
    logic                  cfg_valid_q, cfg_valid_d;
    logic                  cfg_done_q, cfg_done_d;
    logic                  load_done;
    logic [NUM_PADS-1:0]   soc_dir;
    logic [NUM_PADS-1:0]   inpad_comb;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        chain_d     = chain_q;
        act_dir_d   = act_dir_q;
        act_inv_d   = act_inv_q;
        cfg_valid_d = cfg_valid_q;
        cfg_done_d  = cfg_done_q;
        load_done   = 1'b0;
        if (ccff_en) begin
            chain_d = {chain_q[CFG_BITS-2:0], ccff_head};
            case (state_q)
                UNCFG, CFG: begin
                    state_d = SHIFT;
                    count_d = CNT_W'(1);
                end
                SHIFT: begin
                    if (count_q == CNT_W'(CFG_BITS - 1)) begin
                        state_d   = CFG;
                        count_d   = '0;
                        load_done = 1'b1;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = UNCFG;
                    count_d = '0;
                end
            endcase
        end
        // Shadow registers only change when a full load completes, so a reload never glitches the pads.
        if (load_done) begin
            for (int i = 0; i < NUM_PADS; i++) begin
                act_dir_d[i] = chain_d[2*i];
                act_inv_d[i] = chain_d[2*i+1];
            end
            cfg_valid_d = 1'b1;
            cfg_done_d  = 1'b1;
        end
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state_q     <= UNCFG;
            count_q     <= '0;
            chain_q     <= '0;
            act_dir_q   <= '0;
            act_inv_q   <= '0;
            cfg_valid_q <= 1'b0;
            cfg_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            chain_q     <= chain_d;
            act_dir_q   <= act_dir_d;
            act_inv_q   <= act_inv_d;
            cfg_valid_q <= cfg_valid_d;
            cfg_done_q  <= cfg_done_d;
        end
    end

    always_comb begin
        soc_dir    = act_dir_q & {NUM_PADS{cfg_valid_q}};
        inpad_comb = (gfpga_pad_EMBEDDED_IO_SOC_IN ^ act_inv_q) & ~soc_dir & {NUM_PADS{cfg_valid_q}};
    end

    assign gfpga_pad_EMBEDDED_IO_SOC_DIR = soc_dir;
    assign gfpga_pad_EMBEDDED_IO_SOC_OUT = (pin_outpad ^ act_inv_q) & soc_dir;
    assign ccff_tail                     = chain_q[CFG_BITS-1];
    assign cfg_done                      = cfg_done_q;

`ifdef GRID_IO_INPAD_REG_EN
    logic [NUM_PADS-1:0] inpad_q, inpad_d;

    always_comb inpad_d = inpad_comb;

    always_ff @(posedge prog_clk) begin
        if (prog_reset) inpad_q <= '0;
        else            inpad_q <= inpad_d;
    end

    assign pin_inpad = inpad_q;
`else
    assign pin_inpad = inpad_comb;
`endif

endmodule
